// File: rtl/ber_pkg.sv
// Shared types and helpers for the bit-error-rate monitor.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ber_state_t;

  // Adds two values that are at most w bits wide (w <= 63) and clamps the
  // result to all-ones of width w. Bit 64 of the result reports that
  // clamping happened.
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [63:0] max_val;
    logic [64:0] sum;
    max_val = (64'd1 << w) - 64'd1;
    sum     = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return {1'b1, max_val};
    end
    return {1'b0, sum[63:0]};
  endfunction

  // Counts the set bits among the lowest w bits of v (w <= 64).
  function automatic logic [7:0] popcount(input logic [63:0] v, input int w);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        cnt = cnt + {7'd0, v[i]};
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// Circular reference delay line: holds the most recent MAX_DELAY pushed
// beats and returns the one pushed rd_delay advances ago, or zeros while
// fewer than rd_delay beats have been pushed since the last clear.
module ber_ref_delay
  import ber_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_DELAY = 64,
  parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DLY_W-1:0]  rd_delay,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(MAX_DELAY);
  localparam int IDX_W = DLY_W + 1;

  logic [DATA_W-1:0] mem [MAX_DELAY];
  logic [PTR_W-1:0]  wr_ptr;
  logic [DLY_W-1:0]  fill;
  logic [IDX_W-1:0]  rd_sum;
  logic [IDX_W-1:0]  rd_wrapped;
  logic [PTR_W-1:0]  rd_idx;

  // The D-th most recent push sits D slots behind the write pointer.
  assign rd_sum     = IDX_W'(wr_ptr) + IDX_W'(MAX_DELAY) - IDX_W'(rd_delay);
  assign rd_wrapped = (rd_sum >= IDX_W'(MAX_DELAY)) ? (rd_sum - IDX_W'(MAX_DELAY)) : rd_sum;
  assign rd_idx     = PTR_W'(rd_wrapped);
  assign rd_data    = ((rd_delay != '0) && (fill >= rd_delay)) ? mem[rd_idx] : '0;

  // Storage needs no reset: the fill count hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Write pointer wraps modulo MAX_DELAY; fill count saturates at MAX_DELAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : (wr_ptr + PTR_W'(1));
      if (fill != DLY_W'(MAX_DELAY)) begin
        fill <= fill + DLY_W'(1);
      end
    end
  end

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: compares decoder beats against a delayed copy of
// the reference stream and accumulates saturating error statistics under
// a start/abort/done controller.
module ber_monitor
  import ber_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_DELAY = 64,
  parameter int CNT_W     = 32,
  parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DLY_W-1:0]  delay,
  input  logic [15:0]       total_beats,
  input  logic              ref_valid,
  input  logic [DATA_W-1:0] ref_data,
  input  logic              advance,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_compared,
  output logic [CNT_W-1:0]  bit_errors,
  output logic [CNT_W-1:0]  beat_errors,
  output logic [15:0]       max_err_run,
  output logic              overflow
);

  ber_state_t        state, state_next;
  logic [DLY_W-1:0]  dly_lat, dly_clamped;
  logic [15:0]       total_lat;
  logic [15:0]       tally, tally_inc;
  logic [15:0]       run_cnt, run_next;
  logic              do_start, do_cmp, do_push;
  logic [DATA_W-1:0] push_data, ref_beat, err_vec;
  logic              err_any;
  logic [7:0]        pop_cnt;
  logic [64:0]       bits_sum, berr_sum, beat_sum, run_sum;
  logic              unused_sat;

  ber_ref_delay #(
    .DATA_W    (DATA_W),
    .MAX_DELAY (MAX_DELAY),
    .DLY_W     (DLY_W)
  ) u_ref_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (do_start),
    .push      (do_push),
    .push_data (push_data),
    .rd_delay  (dly_lat),
    .rd_data   (ref_beat)
  );

  assign push_data = ref_valid ? ref_data : '0;
  assign err_vec   = ref_beat ^ dec_data;
  assign err_any   = |err_vec;
  assign pop_cnt   = popcount(64'(err_vec), DATA_W);
  assign tally_inc = tally + 16'd1;

  assign bits_sum  = sat_add(64'(bits_compared), 64'(DATA_W), CNT_W);
  assign berr_sum  = sat_add(64'(bit_errors), 64'(pop_cnt), CNT_W);
  assign beat_sum  = sat_add(64'(beat_errors), 64'(err_any), CNT_W);
  assign run_sum   = sat_add(64'(run_cnt), 64'd1, 16);
  assign run_next  = err_any ? run_sum[15:0] : 16'd0;

  assign unused_sat = ^{bits_sum[63:CNT_W], berr_sum[63:CNT_W],
                        beat_sum[63:CNT_W], run_sum[63:16]};

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Clamp the requested delay into the supported 1..MAX_DELAY range.
  always_comb begin
    dly_clamped = delay;
    if (delay == '0) begin
      dly_clamped = DLY_W'(1);
    end else if (delay > DLY_W'(MAX_DELAY)) begin
      dly_clamped = DLY_W'(MAX_DELAY);
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes; start overrides abort in every state.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_cmp     = 1'b0;
    do_push    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          do_start   = 1'b1;
          state_next = (total_beats == 16'd0) ? ST_DONE : ST_RUN;
        end else if (abort) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          do_start   = 1'b1;
          state_next = (total_beats == 16'd0) ? ST_DONE : ST_RUN;
        end else if (abort) begin
          state_next = ST_IDLE;
        end else begin
          do_cmp  = dec_valid;
          do_push = advance;
          if (dec_valid && (tally_inc == total_lat)) begin
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Run configuration is captured at start so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_lat   <= '0;
      total_lat <= '0;
    end else if (do_start) begin
      dly_lat   <= dly_clamped;
      total_lat <= total_beats;
    end
  end

  // Result counters: cleared by start, updated once per compared beat,
  // frozen otherwise. The beat tally stops at total_lat so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tally         <= '0;
      run_cnt       <= '0;
      bits_compared <= '0;
      bit_errors    <= '0;
      beat_errors   <= '0;
      max_err_run   <= '0;
      overflow      <= 1'b0;
    end else if (do_start) begin
      tally         <= '0;
      run_cnt       <= '0;
      bits_compared <= '0;
      bit_errors    <= '0;
      beat_errors   <= '0;
      max_err_run   <= '0;
      overflow      <= 1'b0;
    end else if (do_cmp) begin
      tally         <= tally_inc;
      run_cnt       <= run_next;
      bits_compared <= bits_sum[CNT_W-1:0];
      bit_errors    <= berr_sum[CNT_W-1:0];
      beat_errors   <= beat_sum[CNT_W-1:0];
      if (run_next > max_err_run) begin
        max_err_run <= run_next;
      end
      overflow <= overflow | bits_sum[64] | berr_sum[64] | beat_sum[64]
                | (err_any & run_sum[64]);
    end
  end

endmodule

// File: tb/tb_ber_monitor.sv
// Self-checking bench for ber_monitor: random stimulus, a queue-based
// reference model of the delayed stream, and a scoreboard that checks two
// instances (32-bit and 8-bit counters) whenever a run ends.
module tb_ber_monitor;

  localparam int DATA_W    = 4;
  localparam int MAX_DELAY = 64;
  localparam int DLY_W     = 7;
  localparam int CNT_W     = 32;
  localparam int CNT_N     = 8;

  typedef struct {
    bit     exp_busy;
    bit     exp_done;
    longint ev_cyc;
    longint bits;
    longint bit_err;
    longint beat_err;
    longint max_run;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [DLY_W-1:0]  delay;
  logic [15:0]       total_beats;
  logic              ref_valid;
  logic [DATA_W-1:0] ref_data;
  logic              advance;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;

  logic              busy_w, done_w, ovf_w;
  logic [CNT_W-1:0]  bits_w, berr_w, beat_w;
  logic [15:0]       run_w;
  logic              busy_n, done_n, ovf_n;
  logic [CNT_N-1:0]  bits_n, berr_n, beat_n;
  logic [15:0]       run_n;

  exp_t              exp_q[$];
  int                total_cnt = 0;
  int                bad_cnt   = 0;
  longint            cyc       = 0;
  logic [DATA_W-1:0] err_mask [256];
  logic              prev_busy = 1'b0;
  logic              prev_done = 1'b0;

  ber_monitor #(.DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delay(delay),
    .total_beats(total_beats), .ref_valid(ref_valid), .ref_data(ref_data),
    .advance(advance), .dec_valid(dec_valid), .dec_data(dec_data),
    .busy(busy_w), .done(done_w), .bits_compared(bits_w), .bit_errors(berr_w),
    .beat_errors(beat_w), .max_err_run(run_w), .overflow(ovf_w)
  );

  ber_monitor #(.DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_N)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delay(delay),
    .total_beats(total_beats), .ref_valid(ref_valid), .ref_data(ref_data),
    .advance(advance), .dec_valid(dec_valid), .dec_data(dec_data),
    .busy(busy_n), .done(done_n), .bits_compared(bits_n), .bit_errors(berr_n),
    .beat_errors(beat_n), .max_err_run(run_n), .overflow(ovf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input longint act, input longint req);
    total_cnt++;
    if (act != req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sat_ref(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, busy_w, 0);
    check_val({tag, "_done"}, done_w, 0);
    check_val({tag, "_bits"}, bits_w, 0);
    check_val({tag, "_bit_err"}, berr_w, 0);
    check_val({tag, "_beat_err"}, beat_w, 0);
    check_val({tag, "_max_run"}, run_w, 0);
    check_val({tag, "_ovf"}, ovf_w, 0);
    check_val({tag, "_busy_n"}, busy_n, 0);
    check_val({tag, "_done_n"}, done_n, 0);
    check_val({tag, "_bits_n"}, bits_n, 0);
    check_val({tag, "_bit_err_n"}, berr_n, 0);
    check_val({tag, "_beat_err_n"}, beat_n, 0);
    check_val({tag, "_max_run_n"}, run_n, 0);
    check_val({tag, "_ovf_n"}, ovf_n, 0);
  endtask

  // Compare both instances against one expected end-of-run record.
  task automatic checkOutput(input exp_t e);
    longint mw, mn;
    mw = (longint'(1) << CNT_W) - 1;
    mn = (longint'(1) << CNT_N) - 1;
    check_val("event_cycle", cyc, e.ev_cyc);
    check_val("busy", busy_w, e.exp_busy);
    check_val("done", done_w, e.exp_done);
    check_val("bits_compared", bits_w, sat_ref(e.bits, CNT_W));
    check_val("bit_errors", berr_w, sat_ref(e.bit_err, CNT_W));
    check_val("beat_errors", beat_w, sat_ref(e.beat_err, CNT_W));
    check_val("max_err_run", run_w, e.max_run);
    check_val("overflow", ovf_w, (e.bits > mw) || (e.bit_err > mw) || (e.beat_err > mw));
    check_val("busy_n", busy_n, e.exp_busy);
    check_val("done_n", done_n, e.exp_done);
    check_val("bits_compared_n", bits_n, sat_ref(e.bits, CNT_N));
    check_val("bit_errors_n", berr_n, sat_ref(e.bit_err, CNT_N));
    check_val("beat_errors_n", beat_n, sat_ref(e.beat_err, CNT_N));
    check_val("max_err_run_n", run_n, e.max_run);
    check_val("overflow_n", ovf_n, (e.bits > mn) || (e.bit_err > mn) || (e.beat_err > mn));
  endtask

  // Scoreboard monitor: a run ends when busy falls or done rises.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      if ((prev_busy && !busy_w) || (!prev_done && done_w)) begin
        if (exp_q.size() == 0) begin
          check_val("expected_entries", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput(e);
        end
      end
      prev_busy <= busy_w;
      prev_done <= done_w;
    end
  end

  task automatic idle_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    advance   = 1'b0;
    dec_valid = 1'b0;
    ref_valid = 1'b0;
    ref_data  = '0;
    dec_data  = '0;
  endtask

  // One session: start, then random beats until total compares, an abort,
  // a restart, or an asynchronous reset at the requested compare count.
  task automatic applyStimulus(input int total, input int dly_in, input int ref_mode,
                               input int dec_mode, input int adv_pct, input int dv_pct,
                               input int abort_at, input int restart_at, input int reset_at);
    int                d_lat, comps, guard;
    bit                restarted, adv, dv, rv, stopped;
    longint            m_bits, m_berr, m_beat, m_run, m_max;
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] ref_beat, push_val, exp_ref, dec_beat, e_vec;
    exp_t              e;

    d_lat = (dly_in == 0) ? 1 : ((dly_in > MAX_DELAY) ? MAX_DELAY : dly_in);
    @(posedge clk); #1;
    start       = 1'b1;
    abort       = 1'b0;
    delay       = DLY_W'(dly_in);
    total_beats = 16'(total);
    advance     = 1'($urandom_range(1));
    dec_valid   = 1'($urandom_range(1));
    ref_valid   = 1'b1;
    ref_data    = DATA_W'($urandom);
    dec_data    = DATA_W'($urandom);
    comps = 0; m_bits = 0; m_berr = 0; m_beat = 0; m_run = 0; m_max = 0;
    hist.delete();
    restarted = 1'b0;
    stopped   = 1'b0;
    if (total == 0) begin
      e = '{exp_busy: 1'b0, exp_done: 1'b1, ev_cyc: cyc + 1, bits: 0, bit_err: 0,
            beat_err: 0, max_run: 0};
      exp_q.push_back(e);
    end
    guard = 0;
    while (comps < total && guard < 5000 && !stopped) begin
      guard++;
      @(posedge clk); #1;
      start       = 1'b0;
      abort       = 1'b0;
      delay       = DLY_W'($urandom);
      total_beats = 16'($urandom);
      if (reset_at >= 0 && comps == reset_at) begin
        check_val("busy_before_reset", busy_w, 1);
        advance   = 1'b0;
        dec_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dec_valid = 1'b1;
        advance   = 1'b1;
        ref_data  = '1;
        dec_data  = '0;
        repeat (3) @(posedge clk);
        #1 idle_inputs();
        check_zero("post_reset_idle");
        return;
      end
      if (abort_at >= 0 && comps == abort_at) begin
        abort     = 1'b1;
        advance   = 1'b0;
        dec_valid = 1'b0;
        e = '{exp_busy: 1'b0, exp_done: 1'b0, ev_cyc: cyc + 1, bits: m_bits,
              bit_err: m_berr, beat_err: m_beat, max_run: m_max};
        exp_q.push_back(e);
        stopped = 1'b1;
      end else if (restart_at >= 0 && comps == restart_at && !restarted) begin
        restarted   = 1'b1;
        start       = 1'b1;
        abort       = 1'b1;
        delay       = DLY_W'(dly_in);
        total_beats = 16'(total);
        advance     = 1'($urandom_range(1));
        dec_valid   = 1'($urandom_range(1));
        comps = 0; m_bits = 0; m_berr = 0; m_beat = 0; m_run = 0; m_max = 0;
        hist.delete();
      end else begin
        adv      = ($urandom_range(99) < adv_pct);
        dv       = ($urandom_range(99) < dv_pct);
        rv       = (ref_mode == 0) ? ($urandom_range(9) != 0) : 1'b1;
        ref_beat = (ref_mode == 1) ? '1 : DATA_W'($urandom);
        push_val = rv ? ref_beat : '0;
        exp_ref  = (hist.size() >= d_lat) ? hist[hist.size() - d_lat] : '0;
        case (dec_mode)
          0:       dec_beat = exp_ref ^ ((comps < 256) ? err_mask[comps] : '0);
          1:       dec_beat = '0;
          2:       dec_beat = DATA_W'($urandom);
          default: dec_beat = ~exp_ref;
        endcase
        advance   = adv;
        dec_valid = dv;
        ref_valid = rv;
        ref_data  = ref_beat;
        dec_data  = dec_beat;
        if (dv) begin
          e_vec  = exp_ref ^ dec_beat;
          comps++;
          m_bits += DATA_W;
          m_berr += $countones(e_vec);
          if (e_vec != '0) begin
            m_beat++;
            m_run++;
          end else begin
            m_run = 0;
          end
          if (m_run > m_max) m_max = m_run;
        end
        if (adv) hist.push_back(push_val);
        if (dv && comps == total) begin
          e = '{exp_busy: 1'b0, exp_done: 1'b1, ev_cyc: cyc + 1, bits: m_bits,
                bit_err: m_berr, beat_err: m_beat, max_run: m_max};
          exp_q.push_back(e);
        end
      end
    end
    if (guard >= 5000) check_val("cycle_budget", comps, total);
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_val("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_masks();
    for (int i = 0; i < 256; i++) err_mask[i] = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    delay       = '0;
    total_beats = '0;
    idle_inputs();
    clear_masks();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_zero("reset");

    // clean aligned run and error injection on beats 10,11,12 and 50
    applyStimulus(100, 12, 0, 0, 100, 100, -1, -1, -1);
    err_mask[10] = 4'b0001;
    err_mask[11] = 4'b0010;
    err_mask[12] = 4'b1000;
    err_mask[50] = 4'b0111;
    applyStimulus(100, 12, 0, 0, 100, 100, -1, -1, -1);
    clear_masks();

    // fill behaviour and delay clamping
    applyStimulus(40, 12, 1, 1, 100, 100, -1, -1, -1);
    applyStimulus(30, 0, 1, 1, 100, 100, -1, -1, -1);
    applyStimulus(60, 0, 0, 2, 60, 70, -1, -1, -1);
    applyStimulus(90, 100, 1, 1, 100, 100, -1, -1, -1);
    applyStimulus(80, 127, 1, 1, 70, 90, -1, -1, -1);

    // abort at beat 40, then a zero-length run from IDLE
    applyStimulus(100, 5, 0, 2, 80, 100, 40, -1, -1);
    applyStimulus(0, 9, 0, 2, 50, 50, -1, -1, -1);

    // saturation of the narrow instance, then a run showing overflow cleared
    applyStimulus(70, 3, 0, 3, 50, 100, -1, -1, -1);
    applyStimulus(20, 2, 0, 2, 50, 100, -1, -1, -1);

    // restart mid-run with abort asserted alongside start
    applyStimulus(60, 7, 0, 2, 70, 80, -1, 25, -1);

    // random sessions with random error masks
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++)
        err_mask[i] = ($urandom_range(3) == 0) ? DATA_W'($urandom) : '0;
      applyStimulus(int'($urandom_range(150, 1)), int'($urandom_range(127)),
                    int'($urandom_range(1)), int'($urandom_range(3)),
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, -1, -1);
    end
    clear_masks();

    // asynchronous reset mid-run, then normal operation afterwards
    applyStimulus(100, 4, 0, 2, 70, 80, -1, -1, 30);
    for (int i = 0; i < 256; i++)
      err_mask[i] = ($urandom_range(3) == 0) ? DATA_W'($urandom) : '0;
    applyStimulus(50, 20, 0, 0, 60, 60, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
